// File: rtl/apb_dpmem_pkg.sv
// rtl/apb_dpmem_pkg.sv - shared types and constants for the APB master bridge and its neighbours
// Contents: default widths, addr_t/data_t/strb_t, apb_cmd_t command record,
//           apb_mst_state_e master FSM states, default FIFO depth and PREADY timeout.
package apb_dpmem_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int STRB_W             = DATA_W / 8;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
        strb_t strb;
    } apb_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - APB4 bus signal bundle between the bridge (master) and a slave
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB (master to slave);
//          PREADY, PSLVERR, PRDATA (slave to master).
interface apb_master_bridge_if
    import apb_dpmem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - synchronous command FIFO holding queued APB requests
// Ports: PCLK, PRESETn (async active-low); push/push_data write side (ignored when full);
//        pop/pop_data read side (pop_data shows the head entry); full, empty status.
module apb_cmd_fifo
    import apb_dpmem_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type cmd_t = apb_cmd_t
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the push even if the same edge pops an entry.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: the count gates every read of an unwritten slot.
    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready request stream to APB4 master with in-order responses
// Ports: PCLK, PRESETn (async active-low);
//        req_valid/req_ready/req_write/req_addr/req_wdata/req_strb request stream;
//        rsp_valid/rsp_rdata/rsp_slverr/rsp_timeout one-cycle response pulse;
//        apb (master modport) registered APB4 bus.
module apb_master_bridge
    import apb_dpmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    apb_master_bridge_if.master     apb
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } cmd_t;

    cmd_t req_cmd;
    cmd_t head_cmd;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic xfer_done;

    apb_mst_state_e        state_q,   state_d;
    logic [TMO_W-1:0]      tmo_q,     tmo_d;
    logic                  psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q,  pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q,   pstrb_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_slverr_d;
    logic                  rsp_timeout_d;

    assign req_cmd   = {req_write, req_addr, req_wdata, req_strb};
    assign req_ready = !fifo_full;

    apb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .cmd_t (cmd_t)
    ) u_cmd_fifo (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .push      (req_valid),
        .push_data (req_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata;
        rsp_slverr_d  = rsp_slverr;
        rsp_timeout_d = rsp_timeout;
        fifo_pop      = 1'b0;
        xfer_done     = 1'b0;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                tmo_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    xfer_done     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : apb.PRDATA;
                    rsp_slverr_d  = apb.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last allowed wait cycle: abort the transfer.
                    xfer_done     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end

                // Chain straight into the next SETUP so PSEL never drops between queued transfers.
                if (xfer_done) begin
                    tmo_d     = '0;
                    penable_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        psel_d   = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        psel_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // Address/control change only when a new command is taken; they hold otherwise.
        if (fifo_pop) begin
            pwrite_d = head_cmd.write;
            paddr_d  = head_cmd.addr;
            pwdata_d = head_cmd.write ? head_cmd.wdata : '0;
            pstrb_d  = head_cmd.write ? head_cmd.strb  : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_slverr  <= rsp_slverr_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with a behavioural APB slave
module tb_apb_master_bridge;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .apb         (apb)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural APB slave (apb_dpmem-like timing) ----------------
    logic [31:0] smem [64];
    int          acc;
    int          need;
    bit          stuck;
    int          slow;

    always_comb begin
        need        = apb.PWRITE ? ((apb.PADDR < 32'h10) ? 1 : 4 + slow) : 2 + slow;
        apb.PREADY  = apb.PSEL && apb.PENABLE && !stuck && (acc == need - 1);
        apb.PSLVERR = apb.PREADY && apb.PWRITE && (apb.PADDR < 32'h10);
        apb.PRDATA  = (apb.PREADY && !apb.PWRITE) ? smem[apb.PADDR[7:2]] : 32'h0;
    end

    always @(posedge PCLK) begin
        if (!PRESETn) begin
            acc <= 0;
            for (int i = 0; i < 64; i++) smem[i] <= (i == 8) ? 32'hDEADBEEF : 32'h0;
        end else if (apb.PSEL && apb.PENABLE) begin
            if (apb.PREADY) begin
                acc <= 0;
                if (apb.PWRITE && !apb.PSLVERR)
                    for (int b = 0; b < 4; b++)
                        if (apb.PSTRB[b]) smem[apb.PADDR[7:2]][8*b +: 8] <= apb.PWDATA[8*b +: 8];
            end else begin
                acc <= acc + 1;
            end
        end else begin
            acc <= 0;
        end
    end

    // ---------------- reference model and scoreboard queues ----------------
    logic [31:0] ref_mem [64];
    logic [33:0] exp_rsp_q [$];   // {rdata, slverr, timeout}
    logic [68:0] exp_cmd_q [$];   // {write, addr, wdata, strb} as seen on the bus

    function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        i = int'(a[7:2]);
        exp_cmd_q.push_back({w, a, w ? d : 32'h0, w ? s : 4'h0});
        if (stuck) begin
            exp_rsp_q.push_back({32'h0, 1'b1, 1'b1});
        end else if (w) begin
            if (a < 32'h10) begin
                exp_rsp_q.push_back({32'h0, 1'b1, 1'b0});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
                exp_rsp_q.push_back({32'h0, 1'b0, 1'b0});
            end
        end else begin
            exp_rsp_q.push_back({ref_mem[i], 1'b0, 1'b0});
        end
    endfunction

    // ---------------- monitor ----------------
    logic [68:0] snap;
    bit          prev_setup;
    bit          expect_rsp;
    int          acc_run;

    always @(negedge PCLK) begin : mon
        logic [33:0] e;
        logic [68:0] cur;
        logic [68:0] c;
        bit          done;
        if (!PRESETn) begin
            prev_setup <= 1'b0;
            expect_rsp <= 1'b0;
            acc_run    <= 0;
        end else begin
            cur = {apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB};
            if (rsp_valid || expect_rsp) check("rsp_latency", rsp_valid, expect_rsp);
            if (rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_rsp_q.pop_front();
                    check("rsp", {rsp_rdata, rsp_slverr, rsp_timeout}, e);
                end
            end
            if (prev_setup) check("setup_one_cycle", {apb.PSEL, apb.PENABLE}, 2'b11);
            if (apb.PSEL && !apb.PENABLE) begin
                if (exp_cmd_q.size() == 0) begin
                    check("setup_unexpected", 1, 0);
                end else begin
                    c = exp_cmd_q.pop_front();
                    check("apb_cmd", cur, c);
                end
                snap <= cur;
            end
            if (apb.PSEL && apb.PENABLE) begin
                check("cmd_stable", cur, snap);
                done = apb.PREADY || (acc_run + 1 == TMO);
                expect_rsp <= done;
                acc_run    <= done ? 0 : acc_run + 1;
            end else begin
                expect_rsp <= 1'b0;
                acc_run    <= 0;
            end
            prev_setup <= apb.PSEL && !apb.PENABLE;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit accepted = 1'b0;
        int t = 0;
        while (!accepted && t < 300) begin
            @(negedge PCLK);
            req_valid = 1'b1;
            req_write = w;
            req_addr  = a;
            req_wdata = d;
            req_strb  = s;
            if (req_ready) begin
                accepted = 1'b1;
                model(w, a, d, s);
            end
            @(posedge PCLK);
            #1;
            t++;
        end
        req_valid = 1'b0;
        if (!accepted) check("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_rsp_q.size() > 0 && t < 600) begin
            @(negedge PCLK);
            t++;
        end
        if (exp_rsp_q.size() > 0) check("drain_timeout", exp_rsp_q.size(), 0);
    endtask

    initial begin
        int t;
        int gaps;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        stuck     = 1'b0;
        slow      = 0;
        PRESETn   = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_mem[8] = 32'hDEADBEEF;

        repeat (3) @(posedge PCLK);
        #3;
        check("reset_outputs", {apb.PSEL, apb.PENABLE, rsp_valid, rsp_slverr, rsp_timeout, req_ready}, 6'b000001);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("ready_after_reset", req_ready, 1);

        // single read of preloaded word, with issue latency
        push(1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge PCLK); check("lat_idle",   {apb.PSEL, apb.PENABLE}, 2'b00);
        @(negedge PCLK); check("lat_setup",  {apb.PSEL, apb.PENABLE}, 2'b10);
        @(negedge PCLK); check("lat_access", {apb.PSEL, apb.PENABLE}, 2'b11);
        drain();

        // strobed write then read back
        push(1'b1, 32'h24, 32'h11223344, 4'b0101);
        push(1'b0, 32'h24, 32'hFFFFFFFF, 4'hF);
        drain();

        // slave error on low address, following request still issued
        push(1'b1, 32'h05, 32'hCAFEF00D, 4'hF);
        push(1'b0, 32'h20, 32'h0, 4'h0);
        drain();

        // FIFO full and chained transfers behind a slow transfer
        slow = 8;
        push(1'b0, 32'h20, 32'h0, 4'h0);
        t = 0;
        while (!apb.PSEL && t < 50) begin @(negedge PCLK); t++; end
        for (int k = 0; k < DEPTH; k++) push(k[0], 32'h40 + 32'(4 * k), $urandom, 4'hF);
        @(negedge PCLK);
        check("full_ready", req_ready, 0);
        push(1'b0, 32'h44, 32'h0, 4'h0);
        gaps = 0;
        t = 0;
        while (exp_rsp_q.size() > 0 && t < 600) begin
            @(negedge PCLK);
            if (!apb.PSEL && !rsp_valid && exp_rsp_q.size() > 0) gaps++;
            t++;
        end
        check("chain_psel_gaps", gaps, 0);
        drain();
        slow = 0;

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            push(1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge PCLK);
        end
        drain();

        // stuck slave -> timeout
        stuck = 1'b1;
        push(1'b0, 32'h40, 32'h0, 4'h0);
        drain();
        stuck = 1'b0;
        @(negedge PCLK);
        check("idle_after_timeout", {apb.PSEL, apb.PENABLE}, 2'b00);

        // reset during ACCESS with commands queued
        slow = 8;
        push(1'b0, 32'h20, 32'h0, 4'h0);
        push(1'b0, 32'h24, 32'h0, 4'h0);
        push(1'b0, 32'h28, 32'h0, 4'h0);
        t = 0;
        while (!apb.PENABLE && t < 50) begin @(negedge PCLK); t++; end
        check("reached_access", apb.PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_async_bus", {apb.PSEL, apb.PENABLE, rsp_valid}, 3'b000);
        exp_rsp_q.delete();
        exp_cmd_q.delete();
        repeat (2) @(posedge PCLK);
        #3;
        PRESETn = 1'b1;
        repeat (20) @(negedge PCLK);
        check("rst_ready", req_ready, 1);
        check("rst_idle", {apb.PSEL, rsp_valid}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
